lock_plant_model: RTL and testbench
===================================

// Module: lock_plant_model
// PURPOSE
//   Behavioural plant for the canal lock: the far end of the lockSystem interface.
//   - Consumes the controller command bus (outputs[4:0]); produces water levels and the sensor bus (inputs[6:0]).
//   - Timed model of lock water, two gates and one boat.
//   - Lets benches close the loop on lockSystem; flags unsafe command sequences.
// PARAMETERS
//   OUTER_LEVEL  8'd20   fixed outer (low) water level
//   INNER_LEVEL  8'd200  fixed inner (high) water level
//   FLOW_STEP    8'd5    lock level change per flow tick
//   FLOW_DIV     4       clk cycles per flow tick
//   TOL          8'd2    |lock - side| <= TOL counts as level-equal
//   GATE_CYCLES  6       gate travel time, cycles
//   BOAT_CYCLES  8       boat enter/exit time, cycles
// PORTS
//   clk           in   1  single clock, all state on posedge
//   rst           in   1  one clock; reset is synchronous and active-low
//   ctrl_out      in   5  controller commands:
//                          [0] outer gate open, [1] inner gate open,
//                          [2] outer valve, [3] inner valve, [4] lock signal (ignored)
//   arrive_outer  in   1  1-cycle pulse: boat arrives at outer side
//   arrive_inner  in   1  1-cycle pulse: boat arrives at inner side
//   innerWater    out  8  INNER_LEVEL constant
//   outerWater    out  8  OUTER_LEVEL constant
//   lockWater     out  8  modelled lock level
//   ctrl_in       out  7  sensors to controller:
//                          [0] boat at outer, [1] boat at inner, [2] boat in lock,
//                          [3] outer gate OPEN, [4] inner gate OPEN,
//                          [5] lock==outer, [6] lock==inner
//   fault         out  1  sticky unsafe-sequence flag
// BEHAVIOUR
//   Reset (rst==0 at posedge)
//   - lockWater=OUTER_LEVEL; gates CLOSED; boat IDLE; prescaler=0; fault=0.
//   - ctrl_in=7'b0100000.
//   Equality flags
//   - ctrl_in[5]/[6] are combinational from registered levels: |lockWater-side| <= TOL.
//   - Difference is computed 9-bit unsigned-safe.
//   Water
//   - Prescaler counts 0..FLOW_DIV-1; tick when it wraps.
//   - On tick: valve_outer only -> lock moves toward OUTER_LEVEL by FLOW_STEP.
//   - On tick: valve_inner only -> lock moves toward INNER_LEVEL by FLOW_STEP.
//   - On tick: no valve -> hold.
//   - If |diff| <= FLOW_STEP, load the target exactly: no overshoot, no wrap.
//   - Both valves asserted in any cycle -> fault; level holds.
//   Gate FSM (per gate): CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED
//   - CLOSED, cmd=1, side level-equal -> OPENING, counter=GATE_CYCLES.
//   - CLOSED, cmd=1, not level-equal -> fault; stay CLOSED.
//   - OPENING counts down; at 0 -> OPEN.
//   - cmd=0 during OPENING -> CLOSING, counter reloaded.
//   - OPEN, cmd=0 -> CLOSING; after GATE_CYCLES -> CLOSED.
//   - cmd=1 during CLOSING: ignored until CLOSED.
//   - Open sensor is 1 only in OPEN.
//   - Both gates non-CLOSED in the same cycle -> fault.
//   - Valve toward the side opposite a non-CLOSED gate -> fault.
//   Boat FSM: IDLE, WAIT_O, WAIT_I, ENTER, IN_LOCK, EXIT
//   - IDLE + arrive_outer -> WAIT_O; IDLE + arrive_inner -> WAIT_I.
//   - Both arrivals together -> outer wins.
//   - Arrivals outside IDLE are ignored.
//   - WAIT_x + gate x OPEN -> ENTER for BOAT_CYCLES -> IN_LOCK; origin is recorded.
//   - IN_LOCK + opposite gate OPEN -> EXIT for BOAT_CYCLES -> IDLE.
//   - Gate leaving OPEN during ENTER/EXIT -> fault; boat counter freezes until that gate is OPEN again.
//   - ctrl_in[0]=WAIT_O; ctrl_in[1]=WAIT_I; ctrl_in[2]=ENTER|IN_LOCK|EXIT.
//   Fault and reset
//   - fault is sticky until reset; the model keeps running after a fault.
//   - Reset mid-operation overrides all events in that cycle.
// TESTING
//   1 Reset hold 2 cycles -> lockWater=20, ctrl_in=7'b0100000, fault=0.
//   2 ctrl_out=5'b01000 -> lockWater 25 after 4 cycles; 200 exactly after 144 cycles.
//     At that point ctrl_in[6]=1 and ctrl_in[5]=0.
//   3 Lock at 20, ctrl_out[1]=1 -> fault=1 next cycle; inner gate stays CLOSED.
//   4 Full transit: arrive_outer, open outer, wait, close, fill, open inner.
//     -> ctrl_in[3] high 6 cycles after cmd; boat_in_lock after 8 more; IDLE after exit.
//   5 ctrl_out=5'b01100 -> fault=1; lockWater unchanged.
//   6 rst=0 mid-fill (lock=120) -> next cycle lockWater=20, all FSMs reset, fault=0.

Source files
------------

// File: rtl/lock_plant_model_if.sv
// Bus between the canal-lock controller (master) and the behavioural lock plant (slave).
interface lock_plant_model_if;
    logic [4:0] ctrl_out;
    logic       arrive_outer;
    logic       arrive_inner;
    logic [7:0] innerWater;
    logic [7:0] outerWater;
    logic [7:0] lockWater;
    logic [6:0] ctrl_in;
    logic       fault;

    modport master (
        output ctrl_out, arrive_outer, arrive_inner,
        input  innerWater, outerWater, lockWater, ctrl_in, fault
    );

    modport slave (
        input  ctrl_out, arrive_outer, arrive_inner,
        output innerWater, outerWater, lockWater, ctrl_in, fault
    );
endinterface

// File: rtl/lock_plant_model.sv
// Timed plant model of a canal lock: water level, outer/inner gates and one boat.
// Raises a sticky fault on any unsafe command sequence while continuing to run.
module lock_plant_model #(
    parameter logic [7:0] OUTER_LEVEL = 8'd20,
    parameter logic [7:0] INNER_LEVEL = 8'd200,
    parameter logic [7:0] FLOW_STEP   = 8'd5,
    parameter int         FLOW_DIV    = 4,
    parameter logic [7:0] TOL         = 8'd2,
    parameter int         GATE_CYCLES = 6,
    parameter int         BOAT_CYCLES = 8
) (
    input logic clk,
    input logic rst,
    lock_plant_model_if.slave bus
);
    localparam int PW = (FLOW_DIV > 1) ? $clog2(FLOW_DIV) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {G_CLOSED, G_OPENING, G_OPEN, G_CLOSING} gate_state_t;
    typedef enum logic [2:0] {B_IDLE, B_WAIT_O, B_WAIT_I, B_ENTER, B_IN_LOCK, B_EXIT} boat_state_t;

    logic [7:0]    level_q, level_d;
    logic [PW-1:0] presc_q, presc_d;
    gate_state_t   gate_q [2];
    gate_state_t   gate_d [2];
    logic [CW-1:0] gcnt_q [2];
    logic [CW-1:0] gcnt_d [2];
    boat_state_t   boat_q, boat_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          origin_q, origin_d;
    logic          fault_q, fault_d;

    logic       tick, valve_o, valve_i;
    logic [1:0] side_eq, gate_open, gate_busy, gate_fault;
    logic       boat_fault, any_fault;
    logic       unused_lock_signal;

    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    endfunction

    // Moves one flow step toward the target, landing on it exactly when close enough.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (abs_diff(cur, tgt) <= {1'b0, FLOW_STEP}) return tgt;
        else if (cur > tgt)                          return cur - FLOW_STEP;
        else                                         return cur + FLOW_STEP;
    endfunction

    assign unused_lock_signal = bus.ctrl_out[4];
    assign valve_o    = bus.ctrl_out[2];
    assign valve_i    = bus.ctrl_out[3];
    assign tick       = (presc_q == PW'(FLOW_DIV - 1));
    assign side_eq[0] = (abs_diff(level_q, OUTER_LEVEL) <= {1'b0, TOL});
    assign side_eq[1] = (abs_diff(level_q, INNER_LEVEL) <= {1'b0, TOL});

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gate_open[i] = (gate_q[i] == G_OPEN);
            gate_busy[i] = (gate_q[i] != G_CLOSED);
        end
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        level_d = level_q;
        if (tick && !(valve_o && valve_i)) begin
            if (valve_o)      level_d = step_toward(level_q, OUTER_LEVEL);
            else if (valve_i) level_d = step_toward(level_q, INNER_LEVEL);
        end
    end

    // Gate index 0 is the outer gate, index 1 the inner gate.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            gate_d[i]     = gate_q[i];
            gcnt_d[i]     = gcnt_q[i];
            gate_fault[i] = 1'b0;
            case (gate_q[i])
                G_CLOSED: begin
                    if (bus.ctrl_out[i]) begin
                        if (side_eq[i]) begin
                            gate_d[i] = G_OPENING;
                            gcnt_d[i] = CW'(GATE_CYCLES - 1);
                        end else begin
                            gate_fault[i] = 1'b1;
                        end
                    end
                end
                G_OPENING: begin
                    if (!bus.ctrl_out[i]) begin
                        gate_d[i] = G_CLOSING;
                        gcnt_d[i] = CW'(GATE_CYCLES - 1);
                    end else if (gcnt_q[i] <= CW'(1)) begin
                        gate_d[i] = G_OPEN;
                    end else begin
                        gcnt_d[i] = gcnt_q[i] - CW'(1);
                    end
                end
                G_OPEN: begin
                    if (!bus.ctrl_out[i]) begin
                        gate_d[i] = G_CLOSING;
                        gcnt_d[i] = CW'(GATE_CYCLES - 1);
                    end
                end
                G_CLOSING: begin
                    if (gcnt_q[i] <= CW'(1)) gate_d[i] = G_CLOSED;
                    else                     gcnt_d[i] = gcnt_q[i] - CW'(1);
                end
                default: gate_d[i] = G_CLOSED;
            endcase
        end
    end

    // Boat moves only while the gate it is passing through stays fully open.
    always_comb begin
        boat_d     = boat_q;
        bcnt_d     = bcnt_q;
        origin_d   = origin_q;
        boat_fault = 1'b0;
        case (boat_q)
            B_IDLE: begin
                if (bus.arrive_outer)      boat_d = B_WAIT_O;
                else if (bus.arrive_inner) boat_d = B_WAIT_I;
            end
            B_WAIT_O: if (gate_open[0]) begin
                boat_d   = B_ENTER;
                bcnt_d   = CW'(BOAT_CYCLES - 1);
                origin_d = 1'b0;
            end
            B_WAIT_I: if (gate_open[1]) begin
                boat_d   = B_ENTER;
                bcnt_d   = CW'(BOAT_CYCLES - 1);
                origin_d = 1'b1;
            end
            B_ENTER: begin
                if (!gate_open[origin_q])    boat_fault = 1'b1;
                else if (bcnt_q <= CW'(1))   boat_d = B_IN_LOCK;
                else                         bcnt_d = bcnt_q - CW'(1);
            end
            B_IN_LOCK: if (gate_open[~origin_q]) begin
                boat_d = B_EXIT;
                bcnt_d = CW'(BOAT_CYCLES - 1);
            end
            B_EXIT: begin
                if (!gate_open[~origin_q])   boat_fault = 1'b1;
                else if (bcnt_q <= CW'(1))   boat_d = B_IDLE;
                else                         bcnt_d = bcnt_q - CW'(1);
            end
            default: boat_d = B_IDLE;
        endcase
    end

    assign any_fault = (valve_o && valve_i) || (|gate_fault) || boat_fault
                     || (gate_busy[0] && gate_busy[1])
                     || (gate_busy[0] && valve_i) || (gate_busy[1] && valve_o);
    assign fault_d = fault_q || any_fault;

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q  <= OUTER_LEVEL;
            presc_q  <= '0;
            boat_q   <= B_IDLE;
            bcnt_q   <= '0;
            origin_q <= 1'b0;
            fault_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                gate_q[i] <= G_CLOSED;
                gcnt_q[i] <= '0;
            end
        end else begin
            level_q  <= level_d;
            presc_q  <= presc_d;
            boat_q   <= boat_d;
            bcnt_q   <= bcnt_d;
            origin_q <= origin_d;
            fault_q  <= fault_d;
            for (int i = 0; i < 2; i++) begin
                gate_q[i] <= gate_d[i];
                gcnt_q[i] <= gcnt_d[i];
            end
        end
    end

    assign bus.innerWater = INNER_LEVEL;
    assign bus.outerWater = OUTER_LEVEL;
    assign bus.lockWater  = level_q;
    assign bus.fault      = fault_q;
    assign bus.ctrl_in    = {side_eq[1], side_eq[0], gate_open[1], gate_open[0],
                             (boat_q == B_ENTER) || (boat_q == B_IN_LOCK) || (boat_q == B_EXIT),
                             (boat_q == B_WAIT_I), (boat_q == B_WAIT_O)};
endmodule

// File: tb/tb_lock_plant_model.sv
// Self-checking bench for lock_plant_model: directed scenarios plus randomized
// valve traffic compared against an integer water model.
module tb_lock_plant_model;
    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;

    lock_plant_model_if bus ();

    lock_plant_model dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst              = 1'b0;
        bus.ctrl_out     = 5'b0;
        bus.arrive_outer = 1'b0;
        bus.arrive_inner = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.ctrl_out = 5'b0;
        bus.arrive_outer = 1'b0;
        bus.arrive_inner = 1'b0;
        step(2);
        checkCount++;
        if (bus.lockWater !== 8'd20) $display("[TB] FAIL reset_level got %0d want 20", bus.lockWater);
        else passCount++;
        checkCount++;
        if (bus.ctrl_in !== 7'b0100000) $display("[TB] FAIL reset_ctrl_in got %b want 0100000", bus.ctrl_in);
        else passCount++;
        checkCount++;
        if (bus.fault !== 1'b0) $display("[TB] FAIL reset_fault got %b want 0", bus.fault);
        else passCount++;
        checkCount++;
        if (bus.innerWater !== 8'd200 || bus.outerWater !== 8'd20)
            $display("[TB] FAIL side_levels got %0d/%0d want 200/20", bus.innerWater, bus.outerWater);
        else passCount++;
        rst = 1'b1;
    endtask

    task automatic test_fill();
        doReset();
        bus.ctrl_out = 5'b01000;
        step(3);
        checkCount++;
        if (bus.lockWater !== 8'd20) $display("[TB] FAIL fill_pre_tick got %0d want 20", bus.lockWater);
        else passCount++;
        step(1);
        checkCount++;
        if (bus.lockWater !== 8'd25) $display("[TB] FAIL fill_first_tick got %0d want 25", bus.lockWater);
        else passCount++;
        step(140);
        checkCount++;
        if (bus.lockWater !== 8'd200) $display("[TB] FAIL fill_full got %0d want 200", bus.lockWater);
        else passCount++;
        checkCount++;
        if (bus.ctrl_in[6:5] !== 2'b10) $display("[TB] FAIL fill_eq_flags got %b want 10", bus.ctrl_in[6:5]);
        else passCount++;
        step(8);
        checkCount++;
        if (bus.lockWater !== 8'd200 || bus.fault !== 1'b0)
            $display("[TB] FAIL fill_no_overshoot got %0d fault %b want 200 fault 0", bus.lockWater, bus.fault);
        else passCount++;
        bus.ctrl_out = 5'b0;
    endtask

    task automatic test_bad_open();
        doReset();
        bus.ctrl_out = 5'b00010;
        step(1);
        checkCount++;
        if (bus.fault !== 1'b1) $display("[TB] FAIL bad_open_fault got %b want 1", bus.fault);
        else passCount++;
        step(10);
        checkCount++;
        if (bus.ctrl_in[4] !== 1'b0 || bus.fault !== 1'b1)
            $display("[TB] FAIL bad_open_gate got open=%b fault=%b want 0/1", bus.ctrl_in[4], bus.fault);
        else passCount++;
        bus.ctrl_out = 5'b0;
    endtask

    task automatic test_arrivals();
        doReset();
        bus.arrive_outer = 1'b1;
        bus.arrive_inner = 1'b1;
        step(1);
        bus.arrive_outer = 1'b0;
        checkCount++;
        if (bus.ctrl_in[1:0] !== 2'b01) $display("[TB] FAIL arrive_outer_wins got %b want 01", bus.ctrl_in[1:0]);
        else passCount++;
        step(1);
        bus.arrive_inner = 1'b0;
        step(1);
        checkCount++;
        if (bus.ctrl_in[2:0] !== 3'b001) $display("[TB] FAIL arrive_ignored got %b want 001", bus.ctrl_in[2:0]);
        else passCount++;
    endtask

    task automatic test_transit();
        bit reached;
        doReset();
        bus.arrive_outer = 1'b1;
        step(1);
        bus.arrive_outer = 1'b0;
        checkCount++;
        if (bus.ctrl_in[0] !== 1'b1) $display("[TB] FAIL transit_wait_o got %b want 1", bus.ctrl_in[0]);
        else passCount++;
        bus.ctrl_out = 5'b00001;
        step(5);
        checkCount++;
        if (bus.ctrl_in[3] !== 1'b0) $display("[TB] FAIL transit_outer_early got %b want 0", bus.ctrl_in[3]);
        else passCount++;
        step(1);
        checkCount++;
        if (bus.ctrl_in[3] !== 1'b1) $display("[TB] FAIL transit_outer_open got %b want 1", bus.ctrl_in[3]);
        else passCount++;
        step(1);
        checkCount++;
        if (bus.ctrl_in[2:0] !== 3'b100) $display("[TB] FAIL transit_enter got %b want 100", bus.ctrl_in[2:0]);
        else passCount++;
        // Close the outer gate exactly when the boat should be fully inside.
        step(7);
        bus.ctrl_out = 5'b00000;
        step(6);
        bus.ctrl_out = 5'b01000;
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            step(1);
            if (bus.ctrl_in[6] === 1'b1) reached = 1'b1;
        end
        checkCount++;
        if (!reached || bus.lockWater !== 8'd200)
            $display("[TB] FAIL transit_fill got %0d want 200 within 200 cycles", bus.lockWater);
        else passCount++;
        bus.ctrl_out = 5'b00010;
        step(6);
        checkCount++;
        if (bus.ctrl_in[4] !== 1'b1) $display("[TB] FAIL transit_inner_open got %b want 1", bus.ctrl_in[4]);
        else passCount++;
        step(7);
        checkCount++;
        if (bus.ctrl_in[2] !== 1'b1) $display("[TB] FAIL transit_exiting got %b want 1", bus.ctrl_in[2]);
        else passCount++;
        step(1);
        checkCount++;
        if (bus.ctrl_in[2:0] !== 3'b000) $display("[TB] FAIL transit_idle got %b want 000", bus.ctrl_in[2:0]);
        else passCount++;
        checkCount++;
        if (bus.fault !== 1'b0) $display("[TB] FAIL transit_fault got %b want 0", bus.fault);
        else passCount++;
        bus.ctrl_out = 5'b0;
    endtask

    task automatic test_both_valves();
        doReset();
        bus.ctrl_out = 5'b01000;
        step(16);
        bus.ctrl_out = 5'b01100;
        step(8);
        checkCount++;
        if (bus.fault !== 1'b1 || bus.lockWater !== 8'd40)
            $display("[TB] FAIL both_valves got level %0d fault %b want 40/1", bus.lockWater, bus.fault);
        else passCount++;
        bus.ctrl_out = 5'b0;
    endtask

    task automatic test_reset_mid();
        doReset();
        bus.arrive_inner = 1'b1;
        step(1);
        bus.arrive_inner = 1'b0;
        bus.ctrl_out = 5'b01000;
        step(79);
        checkCount++;
        if (bus.lockWater !== 8'd120) $display("[TB] FAIL mid_level got %0d want 120", bus.lockWater);
        else passCount++;
        bus.ctrl_out = 5'b01001;
        step(1);
        bus.arrive_outer = 1'b1;
        rst = 1'b0;
        step(1);
        checkCount++;
        if (bus.lockWater !== 8'd20 || bus.ctrl_in !== 7'b0100000 || bus.fault !== 1'b0)
            $display("[TB] FAIL mid_reset got level %0d ctrl_in %b fault %b want 20/0100000/0",
                     bus.lockWater, bus.ctrl_in, bus.fault);
        else passCount++;
        rst = 1'b1;
        bus.arrive_outer = 1'b0;
        bus.ctrl_out = 5'b0;
    endtask

    task automatic test_random_water();
        int lvl, tgt, n, mode, len, errs;
        doReset();
        lvl  = 20;
        n    = 0;
        errs = 0;
        for (int seg = 0; seg < 24; seg++) begin
            mode = $urandom_range(2, 0);
            len  = $urandom_range(40, 1);
            bus.ctrl_out = (mode == 1) ? 5'b00100 : (mode == 2) ? 5'b01000 : 5'b00000;
            for (int c = 0; c < len; c++) begin
                step(1);
                n++;
                if (n % 4 == 0 && mode != 0) begin
                    tgt = (mode == 1) ? 20 : 200;
                    if ((lvl > tgt ? lvl - tgt : tgt - lvl) <= 5) lvl = tgt;
                    else lvl = (lvl > tgt) ? lvl - 5 : lvl + 5;
                end
                checkCount++;
                if (bus.lockWater !== 8'(lvl) ||
                    bus.ctrl_in[5] !== ((lvl - 20 <= 2) && (20 - lvl <= 2)) ||
                    bus.ctrl_in[6] !== ((lvl - 200 <= 2) && (200 - lvl <= 2))) begin
                    if (errs < 5)
                        $display("[TB] FAIL rand_water cycle %0d got %0d eq %b want %0d", n,
                                 bus.lockWater, bus.ctrl_in[6:5], lvl);
                    errs++;
                end else passCount++;
            end
        end
        checkCount++;
        if (bus.fault !== 1'b0) $display("[TB] FAIL rand_fault got %b want 0", bus.fault);
        else passCount++;
        bus.ctrl_out = 5'b0;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_fill();
        test_bad_open();
        test_arrivals();
        test_transit();
        test_both_valves();
        test_reset_mid();
        test_random_water();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
